// File: rtl/slowmpy_pkg.sv
// Shared definitions for the radix-2^BPC sequential multiplier.
//   f_ndig  : number of multiplier digits processed (ceil(NB/BPC))
//   f_cntw  : width of the digit counter, clog2(NDIG+1)
//   S_*     : controller state encodings
//   SGN_*   : {a_signed, b_signed} selections for the CPU multiply ops
package slowmpy_pkg;

  function automatic int f_ndig(input int nb, input int bpc);
    return (nb + bpc - 1) / bpc;
  endfunction

  function automatic int f_cntw(input int nb, input int bpc);
    return $clog2(f_ndig(nb, bpc) + 1);
  endfunction

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  // {a_signed, b_signed}. MUL keeps only the low half, so signedness does
  // not change its result; signed is used for symmetry with MULH.
  localparam logic [1:0] SGN_MUL    = 2'b11;
  localparam logic [1:0] SGN_MULH   = 2'b11;
  localparam logic [1:0] SGN_MULHSU = 2'b10;
  localparam logic [1:0] SGN_MULHU  = 2'b00;

endpackage

// File: rtl/slowmpy_radix_if.sv
// Request/response bundle of slowmpy_radix.
//   master : requester side (drives i_*, observes o_*)
//   slave  : multiplier side (observes i_*, drives o_*)
interface slowmpy_radix_if #(
  parameter int NA = 32,
  parameter int NB = 32,
  parameter int AW = 1
);
  logic             i_stb;
  logic             i_abort;
  logic             i_a_signed;
  logic             i_b_signed;
  logic [NA-1:0]    i_a;
  logic [NB-1:0]    i_b;
  logic [AW-1:0]    i_aux;
  logic             o_busy;
  logic             o_done;
  logic [NA+NB-1:0] o_p;
  logic [AW-1:0]    o_aux;

  modport master (
    output i_stb, i_abort, i_a_signed, i_b_signed, i_a, i_b, i_aux,
    input  o_busy, o_done, o_p, o_aux
  );

  modport slave (
    input  i_stb, i_abort, i_a_signed, i_b_signed, i_a, i_b, i_aux,
    output o_busy, o_done, o_p, o_aux
  );
endinterface

// File: rtl/slowmpy_digit.sv
// Combinational partial product of one BPC-bit unsigned multiplier digit
// and the (already shifted) W-bit multiplicand.
//   a_i       : multiplicand, aligned to the current digit position
//   dig_i     : multiplier digit, LSB first
//   neg_top_i : bit TOPJ of the digit carries negative weight (the sign
//               bit of a signed multiplier), so its term is subtracted
//   pp_o      : partial product, modulo 2^W
module slowmpy_digit #(
  parameter int W    = 64,
  parameter int BPC  = 2,
  parameter int TOPJ = 1
) (
  input  logic [W-1:0]   a_i,
  input  logic [BPC-1:0] dig_i,
  input  logic           neg_top_i,
  output logic [W-1:0]   pp_o
);

  logic [W-1:0] term [BPC];

  for (genvar gi = 0; gi < BPC; gi++) begin : g_term
    logic [W-1:0] sh;
    assign sh = a_i << gi;
    if (gi == TOPJ) begin : g_top
      assign term[gi] = !dig_i[gi] ? '0 :
                        (neg_top_i ? ({W{1'b0}} - sh) : sh);
    end else begin : g_plain
      assign term[gi] = dig_i[gi] ? sh : '0;
    end
  end

  always_comb begin
    pp_o = '0;
    for (int j = 0; j < BPC; j++) begin
      pp_o = pp_o + term[j];
    end
  end

endmodule

// File: rtl/slowmpy_radix.sv
// Sequential multiplier consuming BPC multiplier bits per clock.
//   i_clk   : clock
//   i_reset : synchronous active-high reset
//   bus     : request (stb/abort/operands/flags/aux) and response
//             (busy/done/product/aux) signals, slave side
// Fixed latency of NDIG+2 edges from the accept edge to o_done. The
// multiplicand register shifts left by BPC each digit while the
// multiplier register shifts right, so the digit unit always sees the
// current digit in the low BPC bits.
module slowmpy_radix
  import slowmpy_pkg::*;
#(
  parameter int NA           = 32,
  parameter int NB           = 32,
  parameter int BPC          = 2,
  parameter int AW           = 1,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  slowmpy_radix_if.slave bus
);

  localparam int W    = NA + NB;
  localparam int NDIG = f_ndig(NB, BPC);
  localparam int CW   = f_cntw(NB, BPC);
  localparam int BW   = NDIG * BPC;
  // Position of the multiplier sign bit inside the last digit.
  localparam int TOPJ = (NB - 1) - (NDIG - 1) * BPC;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [BW-1:0] b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          bs_q, bs_d;
  logic [AW-1:0] aux_q, aux_d;
  logic [W-1:0]  p_q, p_d;
  logic [AW-1:0] oaux_q, oaux_d;
  logic          done_q, done_d;

  logic [W-1:0]  a_ext;
  logic [W-1:0]  pp;
  logic          neg_top;

  assign a_ext   = {{NB{bus.i_a_signed & bus.i_a[NA-1]}}, bus.i_a};
  assign neg_top = bs_q && (cnt_q == LAST);

  slowmpy_digit #(
    .W   (W),
    .BPC (BPC),
    .TOPJ(TOPJ)
  ) u_digit (
    .a_i      (a_q),
    .dig_i    (b_q[BPC-1:0]),
    .neg_top_i(neg_top),
    .pp_o     (pp)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    bs_d    = bs_q;
    aux_d   = aux_q;
    p_d     = p_q;
    oaux_d  = oaux_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_stb) begin
          state_d        = S_RUN;
          cnt_d          = '0;
          a_d            = a_ext;
          // Multiplier is zero-padded; its sign is applied by subtraction.
          b_d            = '0;
          b_d[NB-1:0]    = bus.i_b;
          acc_d          = '0;
          bs_d           = bus.i_b_signed;
          aux_d          = bus.i_aux;
        end else if (OPT_LOWPOWER) begin
          a_d   = '0;
          b_d   = '0;
          acc_d = '0;
          bs_d  = 1'b0;
          aux_d = '0;
        end
      end
      S_RUN: begin
        acc_d = acc_q + pp;
        a_d   = a_q << BPC;
        b_d   = b_q >> BPC;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        p_d     = acc_q;
        oaux_d  = aux_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything while busy, including a pending result.
    if (bus.i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      p_d     = p_q;
      oaux_d  = oaux_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      bs_q    <= 1'b0;
      aux_q   <= '0;
      p_q     <= '0;
      oaux_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      bs_q    <= bs_d;
      aux_q   <= aux_d;
      p_q     <= p_d;
      oaux_q  <= oaux_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_busy = (state_q != S_IDLE);
  assign bus.o_done = done_q;
  assign bus.o_p    = p_q;
  assign bus.o_aux  = oaux_q;

endmodule

// File: tb/tb_slowmpy_radix.sv
module tb_slowmpy_radix;
  import slowmpy_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       stb, abort_r, sa, sb;
  logic [7:0] a, b;
  logic       aux;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  slowmpy_radix_if #(.NA(8), .NB(8), .AW(1)) bus  ();
  slowmpy_radix_if #(.NA(8), .NB(8), .AW(1)) bus3 ();

  assign bus.i_stb       = stb;
  assign bus.i_abort     = abort_r;
  assign bus.i_a_signed  = sa;
  assign bus.i_b_signed  = sb;
  assign bus.i_a         = a;
  assign bus.i_b         = b;
  assign bus.i_aux       = aux;
  assign bus3.i_stb      = stb;
  assign bus3.i_abort    = abort_r;
  assign bus3.i_a_signed = sa;
  assign bus3.i_b_signed = sb;
  assign bus3.i_a        = a;
  assign bus3.i_b        = b;
  assign bus3.i_aux      = aux;

  slowmpy_radix #(.NA(8), .NB(8), .BPC(2), .AW(1), .OPT_LOWPOWER(1'b0)) u_dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus.slave)
  );

  slowmpy_radix #(.NA(8), .NB(8), .BPC(3), .AW(1), .OPT_LOWPOWER(1'b1)) u_dut3 (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus3.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic get_busy(input bit sel);
    return sel ? bus3.o_busy : bus.o_busy;
  endfunction
  function automatic logic get_done(input bit sel);
    return sel ? bus3.o_done : bus.o_done;
  endfunction
  function automatic logic [15:0] get_p(input bit sel);
    return sel ? bus3.o_p : bus.o_p;
  endfunction
  function automatic logic get_aux(input bit sel);
    return sel ? bus3.o_aux : bus.o_aux;
  endfunction

  // One full operation on DUT sel (0: BPC=2, 1: BPC=3), checking latency,
  // busy length, product, tag and the one-cycle done pulse.
  task automatic run_op(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                        input logic [1:0] sgn, input logic auxv,
                        input logic [15:0] exp_p, input int exp_lat, input string tag);
    int n;
    int nbusy;
    stb = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    a = av; b = bv; {sa, sb} = sgn; aux = auxv; stb = 1'b1;
    tick();
    stb = 1'b0;
    n = 1;
    nbusy = 0;
    while (!get_done(sel) && n < 20) begin
      nbusy += int'(get_busy(sel));
      tick();
      n++;
    end
    check({tag, "_lat"},  n, exp_lat);
    check({tag, "_busy"}, nbusy, exp_lat - 1);
    check({tag, "_p"},    get_p(sel), exp_p);
    check({tag, "_aux"},  get_aux(sel), auxv);
    $display("op %s a=%02h b=%02h sgn=%b p=%04h aux=%0d lat=%0d", tag, av, bv, sgn,
             get_p(sel), get_aux(sel), n);
    tick();
    check({tag, "_pulse"}, get_done(sel), 1'b0);
  endtask

  initial begin
    int  n;
    bit  seen;
    rst = 1'b1; stb = 1'b0; abort_r = 1'b0; sa = 1'b0; sb = 1'b0;
    a = '0; b = '0; aux = 1'b0;
    tick(); tick();
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_done", bus.o_done, 1'b0);
    check("rst_p",    bus.o_p, 16'h0000);
    check("rst_aux",  bus.o_aux, 1'b0);
    rst = 1'b0;

    run_op(0, 8'hFF, 8'hFF, SGN_MULHU,  1'b1, 16'hFE01, 6, "unsigned");
    run_op(0, 8'h80, 8'h80, SGN_MULH,   1'b0, 16'h4000, 6, "signed_min");
    run_op(0, 8'hFF, 8'h01, SGN_MULH,   1'b1, 16'hFFFF, 6, "signed_m1");
    run_op(0, 8'h00, 8'h5A, SGN_MULHU,  1'b0, 16'h0000, 6, "zero");
    run_op(0, 8'hFE, 8'hFF, SGN_MULHSU, 1'b1, 16'hFE02, 6, "mixed_su");
    run_op(0, 8'hFF, 8'hFF, 2'b01,      1'b0, 16'hFF01, 6, "mixed_us");

    // Abort at cycle 3: busy drops at cycle 4, no done, outputs held.
    a = 8'd3; b = 8'd5; {sa, sb} = SGN_MULHU; aux = 1'b1; stb = 1'b1;
    tick();
    stb = 1'b0;
    tick(); tick();
    abort_r = 1'b1;
    tick();
    abort_r = 1'b0;
    check("abort_busy", bus.o_busy, 1'b0);
    check("abort_done", bus.o_done, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen |= bus.o_done;
      tick();
    end
    check("abort_nodone", seen, 1'b0);
    check("abort_p",   bus.o_p, 16'hFF01);
    check("abort_aux", bus.o_aux, 1'b0);
    $display("op abort p=%04h aux=%0d", bus.o_p, bus.o_aux);

    // Restart with stb and abort together while idle (accepted), then reset.
    stb = 1'b1; abort_r = 1'b1;
    tick();
    stb = 1'b0; abort_r = 1'b0;
    check("restart_busy", bus.o_busy, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_busy", bus.o_busy, 1'b0);
    check("rstmid_p",    bus.o_p, 16'h0000);
    check("rstmid_aux",  bus.o_aux, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen |= bus.o_done;
      tick();
    end
    check("rstmid_nodone", seen, 1'b0);
    $display("op reset_mid p=%04h aux=%0d", bus.o_p, bus.o_aux);

    // Back-to-back: stb held high; second accept on the first done cycle.
    a = 8'd7; b = 8'd9; {sa, sb} = SGN_MULHU; aux = 1'b0; stb = 1'b1;
    tick();
    a = 8'h10; b = 8'h10; aux = 1'b1;
    n = 1;
    while (!bus.o_done && n < 20) begin
      tick();
      n++;
    end
    check("b2b1_lat", n, 6);
    check("b2b1_p",   bus.o_p, 16'h003F);
    check("b2b1_aux", bus.o_aux, 1'b0);
    $display("op b2b_first p=%04h aux=%0d lat=%0d", bus.o_p, bus.o_aux, n);
    tick();
    stb = 1'b0;
    check("b2b2_accept", bus.o_busy, 1'b1);
    check("b2b_pulse",   bus.o_done, 1'b0);
    n = 1;
    while (!bus.o_done && n < 20) begin
      tick();
      n++;
    end
    check("b2b2_lat", n, 6);
    check("b2b2_p",   bus.o_p, 16'h0100);
    check("b2b2_aux", bus.o_aux, 1'b1);
    $display("op b2b_second p=%04h aux=%0d lat=%0d", bus.o_p, bus.o_aux, n);

    // BPC=3 instance: NDIG=3, latency 5.
    run_op(1, 8'h81, 8'hC3, SGN_MULH, 1'b1, 16'h1E43, 5, "bpc3_signed");
    run_op(1, 8'hFF, 8'hFF, SGN_MULHU, 1'b0, 16'hFE01, 5, "bpc3_unsigned");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
